c_frag_cfg_loader: RTL and testbench

Sequential configuration loader for a column of `NUM_CELLS` C_FRAG logic cells. It accepts one 8-bit input-inverter word per cell over a valid/ready stream and shifts all words into the fabric's serial configuration chain. It then pulses a latch strobe and can optionally read back and verify the chain contents. It sits between the bitstream/config sequencer and the per-column C_FRAG inversion chain.

---
 rtl/c_frag_cfg_pkg.sv | 25 ++
 rtl/c_frag_cfg_shifter.sv | 38 +++
 rtl/c_frag_cfg_loader.sv | 169 ++++++++++++++++
 tb/tb_c_frag_cfg_loader.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/c_frag_cfg_pkg.sv
// Shared types and constants for the C_FRAG column configuration loader.
package c_frag_cfg_pkg;

  localparam int unsigned CFG_W = 8;

  // Bit positions of the input-inverter controls inside a config word
  localparam int unsigned INV_TAS1 = 0;
  localparam int unsigned INV_TAS2 = 1;
  localparam int unsigned INV_TBS1 = 2;
  localparam int unsigned INV_TBS2 = 3;
  localparam int unsigned INV_BAS1 = 4;
  localparam int unsigned INV_BAS2 = 5;
  localparam int unsigned INV_BBS1 = 6;
  localparam int unsigned INV_BBS2 = 7;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShift,
    StLatch,
    StVerify,
    StFin
  } state_e;

endpackage

// File: rtl/c_frag_cfg_shifter.sv
// Parallel-in/serial-out word shifter. Holds the bits of the current word that
// have not yet been presented and flags the final shift cycle of a word.
module c_frag_cfg_shifter
  import c_frag_cfg_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [CFG_W-1:0] data_i,
  output logic             next_bit_o,
  output logic             last
);

  localparam int unsigned BitW = $clog2(CFG_W);

  logic [CFG_W-2:0] sr_q;
  logic [BitW-1:0]  cnt_q;

  // Bit 0 leaves through the registered SDO at load time; keep the rest here
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      sr_q  <= data_i[CFG_W-1:1];
      cnt_q <= '0;
    end else if (shift_i) begin
      sr_q  <= sr_q >> 1;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Bit the serial output must carry in the following cycle
  assign next_bit_o = load_i ? data_i[0] : sr_q[0];
  assign last       = shift_i && (cnt_q == BitW'(CFG_W - 1));

endmodule

// File: rtl/c_frag_cfg_loader.sv
// Serial configuration loader for a column of C_FRAG cells: accepts one
// inverter word per cell, shifts the words into the chain, then strobes LATCH.
// Define C_FRAG_CFG_VERIFY_EN to add shadow storage, a readback VERIFY pass
// and the sticky ERR flag; otherwise ERR is tied low.
module c_frag_cfg_loader
  import c_frag_cfg_pkg::*;
#(
  parameter int unsigned NUM_CELLS = 4,
  parameter int unsigned CNT_W     = $clog2(NUM_CELLS * 8 + 1)
) (
  input  logic             QCK,
  input  logic             QRT,
  input  logic             START,
  input  logic             CFG_VALID,
  output logic             CFG_READY,
  input  logic [CFG_W-1:0] CFG_DATA,
  output logic             SDO,
  output logic             SEN,
  input  logic             SDI,
  output logic             LATCH,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);

  localparam int unsigned TotalBits = NUM_CELLS * CFG_W;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic             accept;
  logic             shift_bit;
  logic             word_last;
  logic             sdo_d;

  assign accept = (state_q == StLoad) && CFG_VALID && CFG_READY;

  c_frag_cfg_shifter u_shifter (
    .clk_i      (QCK),
    .rst_i      (QRT),
    .load_i     (accept),
    .shift_i    (state_q == StShift),
    .data_i     (CFG_DATA),
    .next_bit_o (shift_bit),
    .last       (word_last)
  );

`ifdef C_FRAG_CFG_VERIFY_EN
  logic [TotalBits-1:0] shadow_q;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 replay_bit;
  logic                 err_d;

  // Keep a copy of every accepted word in arrival order for the replay pass
  always_ff @(posedge QCK) begin
    if (QRT) begin
      shadow_q <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_CELLS); i++) begin
        if (accept && (word_cnt_q == CNT_W'(i))) begin
          shadow_q[i*CFG_W +: CFG_W] <= CFG_DATA;
        end
      end
    end
  end

  // Replay index of the bit SDO presents next cycle
  always_comb begin
    bit_cnt_d  = (state_q == StVerify) ? bit_cnt_q + 1'b1 : '0;
    replay_bit = 1'b0;
    for (int i = 0; i < int'(TotalBits); i++) begin
      if (bit_cnt_d == CNT_W'(i)) replay_bit = shadow_q[i];
    end
    // SDO already carries the stored bit for this cycle, so compare against it
    err_d = ERR;
    if ((state_q == StIdle) && START) begin
      err_d = 1'b0;
    end else if ((state_q == StVerify) && (SDI != SDO)) begin
      err_d = 1'b1;
    end
  end

  // Readback index and sticky mismatch flag
  always_ff @(posedge QCK) begin
    if (QRT) begin
      bit_cnt_q <= '0;
      ERR       <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      ERR       <= err_d;
    end
  end
`else
  logic unused_sdi;
  assign unused_sdi = SDI;
  assign ERR        = 1'b0;
`endif

  // Sequencer next state
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (START) begin
          state_d    = StLoad;
          word_cnt_d = '0;
        end
      end
      StLoad: begin
        if (accept) state_d = StShift;
      end
      StShift: begin
        if (word_last) begin
          word_cnt_d = word_cnt_q + 1'b1;
          state_d    = (word_cnt_d == CNT_W'(NUM_CELLS)) ? StLatch : StLoad;
        end
      end
      StLatch: begin
`ifdef C_FRAG_CFG_VERIFY_EN
        state_d = StVerify;
`else
        state_d = StFin;
`endif
      end
      StVerify: begin
`ifdef C_FRAG_CFG_VERIFY_EN
        if (bit_cnt_q == CNT_W'(TotalBits - 1)) state_d = StFin;
`else
        state_d = StIdle;
`endif
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Serial data for the next cycle: live word while shifting, stored stream on replay
  always_comb begin
    sdo_d = 1'b0;
    if (state_d == StShift) sdo_d = shift_bit;
`ifdef C_FRAG_CFG_VERIFY_EN
    if (state_d == StVerify) sdo_d = replay_bit;
`endif
  end

  // State and registered outputs, all decoded from the next state
  always_ff @(posedge QCK) begin
    if (QRT) begin
      state_q    <= StIdle;
      word_cnt_q <= '0;
      CFG_READY  <= 1'b0;
      SDO        <= 1'b0;
      SEN        <= 1'b0;
      LATCH      <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      CFG_READY  <= (state_d == StLoad);
      SDO        <= sdo_d;
      SEN        <= (state_d == StShift) || (state_d == StVerify);
      LATCH      <= (state_d == StLatch);
      BUSY       <= (state_d != StIdle);
      DONE       <= (state_d == StFin);
    end
  end

endmodule

// File: tb/tb_c_frag_cfg_loader.sv
// Bench for c_frag_cfg_loader: a 4-cell and a 1-cell instance, each with a
// shift-register model of its configuration chain, checked cycle by cycle
// against a schedule computed from the word arrival times.
module tb_c_frag_cfg_loader;

`ifdef C_FRAG_CFG_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       qrt, start4, start1, cfg_valid;
  logic [7:0] cfg_data;
  logic ready4, sdo4, sen4, latch4, busy4, done4, err4, sdi4;
  logic ready1, sdo1, sen1, latch1, busy1, done1, err1, sdi1;

  logic [31:0] chain4   = '0;
  logic [7:0]  chain1   = '0;
  logic        flip_now = 1'b0;
  logic        sel      = 1'b0;

  c_frag_cfg_loader #(.NUM_CELLS(4)) dut4 (
    .QCK(clk), .QRT(qrt), .START(start4), .CFG_VALID(cfg_valid), .CFG_READY(ready4),
    .CFG_DATA(cfg_data), .SDO(sdo4), .SEN(sen4), .SDI(sdi4), .LATCH(latch4),
    .BUSY(busy4), .DONE(done4), .ERR(err4)
  );

  c_frag_cfg_loader #(.NUM_CELLS(1)) dut1 (
    .QCK(clk), .QRT(qrt), .START(start1), .CFG_VALID(cfg_valid), .CFG_READY(ready1),
    .CFG_DATA(cfg_data), .SDO(sdo1), .SEN(sen1), .SDI(sdi1), .LATCH(latch1),
    .BUSY(busy1), .DONE(done1), .ERR(err1)
  );

  // Fabric chains: head takes SDO, tail returns SDI
  always @(posedge clk) if (sen4) chain4 <= {sdo4, chain4[31:1]};
  always @(posedge clk) if (sen1) chain1 <= {sdo1, chain1[7:1]};
  assign sdi4 = chain4[0] ^ (flip_now & ~sel);
  assign sdi1 = chain1[0] ^ (flip_now & sel);

  logic m_ready, m_sdo, m_sen, m_latch, m_busy, m_done, m_err;
  assign m_ready = sel ? ready1 : ready4;
  assign m_sdo   = sel ? sdo1   : sdo4;
  assign m_sen   = sel ? sen1   : sen4;
  assign m_latch = sel ? latch1 : latch4;
  assign m_busy  = sel ? busy1  : busy4;
  assign m_done  = sel ? done1  : done4;
  assign m_err   = sel ? err1   : err4;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] words[64];
  int         gaps[64];
  bit         err_model = 1'b0;

  task automatic chk(input string tag, input int t, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s cycle %0d: observed %b expected %b", tag, t, obs, exp);
    end
  endtask

  // One load sequence; START is in cycle 0. gaps[i] = idle LOAD cycles before word i.
  task automatic run_seq(input bit s, input int n, input int flip, input bit do_abort);
    int acc[64];
    int lat, done_t, last_t, abort_at, flip_t, idx;
    bit dead, busy_now, st;
    logic e_ready, e_sdo, e_sen, e_latch, e_busy, e_done, e_err;
    sel    = s;
    acc[0] = 1 + gaps[0];
    for (int i = 1; i < n; i++) acc[i] = acc[i-1] + 9 + gaps[i];
    lat      = acc[n-1] + 9;
    done_t   = VER ? lat + 1 + n * 8 : lat + 1;
    abort_at = do_abort ? acc[2] + 3 : -1;
    last_t   = do_abort ? abort_at + 20 : done_t + 3;
    flip_t   = (VER && flip >= 0) ? lat + 1 + flip : -1;
    for (int t = 0; t <= last_t; t++) begin
      dead     = do_abort && (t > abort_at);
      busy_now = (t >= 1) && (t <= done_t);
      qrt      = (t == abort_at);
      st = (t == 0) || (!dead && busy_now && t != abort_at && $urandom_range(0, 7) == 0);
      start4    = s ? 1'b0 : st;
      start1    = s ? st : 1'b0;
      cfg_valid = 1'($urandom_range(0, 1));
      cfg_data  = 8'($urandom);
      for (int i = 0; i < n; i++) begin
        if (t >= acc[i] - gaps[i] && t <= acc[i]) begin
          cfg_valid = (t == acc[i]);
          cfg_data  = words[i];
        end
      end
      flip_now = (t == flip_t);
      // Expected outputs for this cycle
      e_ready = 1'b0;
      e_sen   = 1'b0;
      e_sdo   = 1'b0;
      for (int i = 0; i < n; i++) begin
        if (t >= acc[i] - gaps[i] && t <= acc[i]) e_ready = 1'b1;
        if (t >= acc[i] + 1 && t <= acc[i] + 8) begin
          e_sen = 1'b1;
          e_sdo = words[i][t - acc[i] - 1];
        end
      end
      if (VER && t >= lat + 1 && t <= lat + n * 8) begin
        idx   = t - lat - 1;
        e_sen = 1'b1;
        e_sdo = words[idx / 8][idx % 8];
      end
      e_latch = (t == lat);
      e_done  = (t == done_t);
      e_busy  = busy_now;
      e_err   = (t == 0) ? err_model : (flip_t >= 0 && t > flip_t);
      if (dead) {e_ready, e_sen, e_sdo, e_latch, e_done, e_busy, e_err} = '0;
      @(negedge clk);
      chk("cfg_ready", t, m_ready, e_ready);
      chk("sen",       t, m_sen,   e_sen);
      chk("sdo",       t, m_sdo,   e_sdo);
      chk("latch",     t, m_latch, e_latch);
      chk("busy",      t, m_busy,  e_busy);
      chk("done",      t, m_done,  e_done);
      chk("err",       t, m_err,   e_err);
      @(posedge clk);
      #1;
    end
    err_model = !do_abort && (flip_t >= 0);
    start4    = 1'b0;
    start1    = 1'b0;
    qrt       = 1'b0;
    flip_now  = 1'b0;
  endtask

  task automatic rand_words(input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      words[i] = 8'($urandom);
      gaps[i]  = int'($urandom_range(0, max_gap));
    end
  endtask

  initial begin
    qrt       = 1'b1;
    start4    = 1'b0;
    start1    = 1'b0;
    cfg_valid = 1'b1;
    cfg_data  = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    qrt = 1'b0;
    @(negedge clk);
    chk("rst_ready4", 0, ready4, 1'b0);
    chk("rst_sdo4",   0, sdo4,   1'b0);
    chk("rst_sen4",   0, sen4,   1'b0);
    chk("rst_latch4", 0, latch4, 1'b0);
    chk("rst_busy4",  0, busy4,  1'b0);
    chk("rst_done4",  0, done4,  1'b0);
    chk("rst_err4",   0, err4,   1'b0);
    chk("rst_ready1", 0, ready1, 1'b0);
    chk("rst_busy1",  0, busy1,  1'b0);
    chk("rst_done1",  0, done1,  1'b0);
    @(posedge clk);
    #1;

    // Directed words, valid always high
    words[0] = 8'h01; words[1] = 8'h80; words[2] = 8'hA5; words[3] = 8'hFF;
    for (int i = 0; i < 4; i++) gaps[i] = 0;
    run_seq(1'b0, 4, -1, 1'b0);
    // Five-cycle valid gap before the third word
    gaps[2] = 5;
    run_seq(1'b0, 4, -1, 1'b0);
    // Readback corruption at replay index 13, then ERR must persist to the next START
    rand_words(4, 0);
    run_seq(1'b0, 4, 13, 1'b0);
    rand_words(4, 2);
    run_seq(1'b0, 4, -1, 1'b0);
    // Reset in the third SHIFT cycle of word 3, then a clean sequence
    rand_words(4, 1);
    run_seq(1'b0, 4, -1, 1'b1);
    rand_words(4, 0);
    run_seq(1'b0, 4, -1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      rand_words(4, 3);
      run_seq(1'b0, 4, ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 31)) : -1, 1'b0);
    end

    // Single-cell instance
    words[0] = 8'h3C;
    gaps[0]  = 0;
    run_seq(1'b1, 1, -1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      rand_words(1, 3);
      run_seq(1'b1, 1, ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : -1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
